// File: rtl/spi_slave_core_if.sv
// SPI pins and register-bus bundle for spi_slave_core.
interface spi_slave_core_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic              I_sclk;
    logic              _I_csb;
    logic              I_sdi;
    logic [DATA_W-1:0] I_rdata;
    logic              O_sdo;
    logic              O_sdo_oe;
    logic [ADDR_W-1:0] O_addr;
    logic [DATA_W-1:0] O_wdata;
    logic              O_wr;
    logic              O_rd;
    logic              O_busy;

    modport slave (
        input  I_sclk, _I_csb, I_sdi, I_rdata,
        output O_sdo, O_sdo_oe, O_addr, O_wdata, O_wr, O_rd, O_busy
    );

    modport master (
        output I_sclk, _I_csb, I_sdi, I_rdata,
        input  O_sdo, O_sdo_oe, O_addr, O_wdata, O_wr, O_rd, O_busy
    );
endinterface

// File: rtl/spi_slave_core.sv
// System-clock-synchronous SPI slave: oversampled SCLK/CSB/SDI, instruction decode, register bus, SDO.
// Optional macro SPI_LSB_FIRST_EN adds I_lsb_first for LSB-first framing on SDI and SDO.
module spi_slave_core #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int ADDR_DESCEND = 1
) (
    input  logic            I_clk,
    input  logic            _I_rst,
`ifdef SPI_LSB_FIRST_EN
    input  logic            I_lsb_first,
`endif
    spi_slave_core_if.slave bus
);

    localparam int INST_W = 3 + ADDR_W;
    localparam int MAX_W  = (INST_W > DATA_W) ? INST_W : DATA_W;
    localparam int CNT_W  = $clog2(MAX_W + 1);
    localparam int FL_W   = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] INST_LAST = CNT_W'(INST_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [FL_W-1:0]  FLUSHED   = FL_W'(SYNC_STAGES);

    typedef enum logic [1:0] {S_IDLE, S_INST, S_DATA, S_DONE} state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_csb_sync;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic [FL_W-1:0]        r_flush_cnt;
    logic                   r_armed;
    logic                   r_lsb;
    logic [INST_W-1:0]      r_inst_sh;
    logic [DATA_W-1:0]      r_data_sh;
    logic [DATA_W-1:0]      r_sdo_sh;
    logic [CNT_W-1:0]       r_bitcnt;
    logic [1:0]             r_wordcnt;
    logic                   r_rw;
    logic [1:0]             r_wcnt;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_wdata;
    logic                   r_wr;
    logic                   r_rd;
    logic                   r_rd_p1;
    logic                   r_rd_p2;
    logic                   r_step_pend;
    logic                   r_sdo;
    logic                   r_sdo_oe;
    logic                   r_busy;

    logic                   w_rise;
    logic                   w_fall;
    logic                   w_csb;
    logic                   w_sdi;
    logic                   w_lsb_in;
    logic                   w_start;
    logic                   w_inst_done;
    logic                   w_word_done;
    logic                   w_last_word;
    logic [INST_W-1:0]      w_inst_next;
    logic [DATA_W-1:0]      w_data_next;

    function automatic logic [ADDR_W-1:0] f_step_addr(input logic [ADDR_W-1:0] a);
        if (ADDR_DESCEND != 0) return a - ADDR_W'(1);
        return a + ADDR_W'(1);
    endfunction

`ifdef SPI_LSB_FIRST_EN
    assign w_lsb_in = I_lsb_first;
`else
    assign w_lsb_in = 1'b0;
`endif

    // SCLK events come from the two oldest stages; SDI is taken from the oldest so it has settled.
    assign w_rise      = r_sclk_sync[SYNC_STAGES-2] & ~r_sclk_sync[SYNC_STAGES-1];
    assign w_fall      = ~r_sclk_sync[SYNC_STAGES-2] & r_sclk_sync[SYNC_STAGES-1];
    assign w_csb       = r_csb_sync[SYNC_STAGES-1];
    assign w_sdi       = r_sdi_sync[SYNC_STAGES-1];
    assign w_inst_next = r_lsb ? {w_sdi, r_inst_sh[INST_W-1:1]} : {r_inst_sh[INST_W-2:0], w_sdi};
    assign w_data_next = r_lsb ? {w_sdi, r_data_sh[DATA_W-1:1]} : {r_data_sh[DATA_W-2:0], w_sdi};
    assign w_last_word = (r_wcnt != 2'd3) && (r_wordcnt == r_wcnt);

    always_ff @(posedge I_clk) begin
        if (!_I_rst) begin
            r_sclk_sync <= '0;
            r_csb_sync  <= '1;
            r_sdi_sync  <= '0;
            r_flush_cnt <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.I_sclk};
            r_csb_sync  <= {r_csb_sync[SYNC_STAGES-2:0], bus._I_csb};
            r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], bus.I_sdi};
            // Arm only once a real CSB-high has crossed the synchroniser after reset.
            if (r_flush_cnt != FLUSHED) r_flush_cnt <= r_flush_cnt + 1'b1;
            else if (w_csb)             r_armed     <= 1'b1;
        end
    end

    always_ff @(posedge I_clk) begin
        if (!_I_rst) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_inst_done  = 1'b0;
        w_word_done  = 1'b0;
        if (w_csb) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (r_armed) begin
                    w_start      = 1'b1;
                    w_state_next = S_INST;
                end
                S_INST: if (w_rise && (r_bitcnt == INST_LAST)) begin
                    w_inst_done  = 1'b1;
                    w_state_next = S_DATA;
                end
                S_DATA: if (w_rise && (r_bitcnt == DATA_LAST)) begin
                    w_word_done = 1'b1;
                    if (w_last_word) w_state_next = S_DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge I_clk) begin
        if (!_I_rst) begin
            r_lsb       <= 1'b0;
            r_inst_sh   <= '0;
            r_data_sh   <= '0;
            r_sdo_sh    <= '0;
            r_bitcnt    <= '0;
            r_wordcnt   <= '0;
            r_rw        <= 1'b0;
            r_wcnt      <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wr        <= 1'b0;
            r_rd        <= 1'b0;
            r_rd_p1     <= 1'b0;
            r_rd_p2     <= 1'b0;
            r_step_pend <= 1'b0;
            r_sdo       <= 1'b0;
            r_sdo_oe    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_wr        <= 1'b0;
            r_rd        <= 1'b0;
            r_step_pend <= 1'b0;
            r_rd_p1     <= r_rd;
            r_rd_p2     <= r_rd_p1;
            // Write address steps one cycle late so O_addr still names the word during O_wr.
            if (r_step_pend) r_addr <= f_step_addr(r_addr);
            if (w_csb) begin
                r_busy    <= 1'b0;
                r_sdo_oe  <= 1'b0;
                r_sdo     <= 1'b0;
                r_bitcnt  <= '0;
                r_wordcnt <= '0;
                r_rd_p1   <= 1'b0;
                r_rd_p2   <= 1'b0;
            end else begin
                if (w_start) begin
                    r_busy    <= 1'b1;
                    r_bitcnt  <= '0;
                    r_wordcnt <= '0;
                    r_lsb     <= w_lsb_in;
                end
                if ((r_state == S_INST) && w_rise) begin
                    r_inst_sh <= w_inst_next;
                    r_bitcnt  <= r_bitcnt + 1'b1;
                    if (w_inst_done) begin
                        r_bitcnt <= '0;
                        r_rw     <= w_inst_next[INST_W-1];
                        r_wcnt   <= w_inst_next[INST_W-2 -: 2];
                        r_addr   <= w_inst_next[ADDR_W-1:0];
                        r_rd     <= w_inst_next[INST_W-1];
                    end
                end
                if (r_state == S_DATA) begin
                    if (w_rise) begin
                        r_data_sh <= w_data_next;
                        r_bitcnt  <= r_bitcnt + 1'b1;
                    end
                    if (w_word_done) begin
                        r_bitcnt  <= '0;
                        r_wordcnt <= r_wordcnt + 1'b1;
                        if (w_last_word) r_sdo_oe <= 1'b0;
                        if (!r_rw) begin
                            r_wr        <= 1'b1;
                            r_wdata     <= w_data_next;
                            r_step_pend <= 1'b1;
                        end else begin
                            r_addr <= f_step_addr(r_addr);
                            r_rd   <= ~w_last_word;
                        end
                    end
                    if (w_fall && r_rw) begin
                        r_sdo_oe <= 1'b1;
                        r_sdo    <= r_lsb ? r_sdo_sh[0] : r_sdo_sh[DATA_W-1];
                        r_sdo_sh <= r_lsb ? {1'b0, r_sdo_sh[DATA_W-1:1]}
                                          : {r_sdo_sh[DATA_W-2:0], 1'b0};
                    end
                    // Prefetched read data lands two cycles after O_rd, well before the next fall.
                    if (r_rd_p2) r_sdo_sh <= bus.I_rdata;
                end
            end
        end
    end

    assign bus.O_sdo    = r_sdo;
    assign bus.O_sdo_oe = r_sdo_oe;
    assign bus.O_addr   = r_addr;
    assign bus.O_wdata  = r_wdata;
    assign bus.O_wr     = r_wr;
    assign bus.O_rd     = r_rd;
    assign bus.O_busy   = r_busy;

endmodule
